demux_32bits_4saidas_reg: RTL and testbench

- Registered 1-to-4 distributor: takes one 32-bit word plus a 2-bit `key` and delivers it to one of four consumer lanes.
- It is the write-side counterpart of the 4-input result selector. A result leaving a datapath stage is steered to one of four destinations (e.g. register-file write port, HI, LO, store-data path).
- Each lane has a one-entry output register with a valid/ready handshake, so a stalled consumer never corrupts the others.

---
 rtl/demux_32bits_4saidas_reg_pkg.sv | 19 +
 rtl/demux_32bits_4saidas_reg_registro_saida_hs.sv | 64 ++++++
 rtl/demux_32bits_4saidas_reg.sv | 82 ++++++++
 tb/tb_demux_32bits_4saidas_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/demux_32bits_4saidas_reg_pkg.sv
// Shared definitions for the registered 1-to-4 result distributor.
package demux_32bits_4saidas_reg_pkg;

    // Default word width of the datapath results being distributed.
    localparam int LARGURA_PADRAO = 32;

    // Destination lane indices, matching the value carried on key.
    localparam logic [1:0] LANE_BANCO = 2'd0;
    localparam logic [1:0] LANE_HI    = 2'd1;
    localparam logic [1:0] LANE_LO    = 2'd2;
    localparam logic [1:0] LANE_MEM   = 2'd3;

    // Occupancy of a one-entry lane register.
    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

endpackage

// File: rtl/demux_32bits_4saidas_reg_registro_saida_hs.sv
// One-entry valid/ready output register for a single distributor lane.
module registro_saida_hs
    import demux_32bits_4saidas_reg_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               escrita,
    input  logic [LARGURA-1:0] dado,
    input  logic               pronta,
    output logic [LARGURA-1:0] saida,
    output logic               valida,
    output logic               pode_aceitar
);

    estado_t            estado_p1;
    estado_t            estado_prox;
    logic [LARGURA-1:0] dado_p1;

    // Lane occupancy register; reset empties the lane immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_p1 <= VAZIO;
        end else begin
            estado_p1 <= estado_prox;
        end
    end

    // Next occupancy: a write always fills, a take without a refill empties.
    always_comb begin
        estado_prox = estado_p1;
        case (estado_p1)
            VAZIO: begin
                if (escrita) begin
                    estado_prox = CHEIO;
                end
            end
            CHEIO: begin
                if (pronta && !escrita) begin
                    estado_prox = VAZIO;
                end
            end
            default: begin
                estado_prox = VAZIO;
            end
        endcase
    end

    // Lane data: loaded on write, held otherwise (a drain does not clear it).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dado_p1 <= '0;
        end else if (escrita) begin
            dado_p1 <= dado;
        end
    end

    assign saida        = dado_p1;
    assign valida       = (estado_p1 == CHEIO);
    // Free slot either because the lane is empty or because it drains this cycle.
    assign pode_aceitar = !valida || pronta;

endmodule

// File: rtl/demux_32bits_4saidas_reg.sv
// Registered 1-to-4 distributor: steers one word per cycle to the lane chosen by key.
module demux_32bits_4saidas_reg
    import demux_32bits_4saidas_reg_pkg::*;
#(
    parameter int LARGURA    = LARGURA_PADRAO,
    parameter int NUM_SAIDAS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [LARGURA-1:0]    entrada,
    input  logic [1:0]            key,
    input  logic                  entrada_valida,
    output logic                  entrada_pronta,
    output logic [LARGURA-1:0]    saida1,
    output logic [LARGURA-1:0]    saida2,
    output logic [LARGURA-1:0]    saida3,
    output logic [LARGURA-1:0]    saida4,
    output logic [NUM_SAIDAS-1:0] saida_valida,
    input  logic [NUM_SAIDAS-1:0] saida_pronta,
    output logic                  ocupado
);

    logic [NUM_SAIDAS-1:0] sel;
    logic [NUM_SAIDAS-1:0] escrita;
    logic [NUM_SAIDAS-1:0] pode_aceitar;
    logic [LARGURA-1:0]    dados [NUM_SAIDAS];
    logic                  aceita;

    // Decode key into a one-hot lane select and pick that lane's accept term.
    always_comb begin
        sel            = '0;
        entrada_pronta = pode_aceitar[0];
        case (key)
            LANE_BANCO: begin
                sel[0]         = 1'b1;
                entrada_pronta = pode_aceitar[0];
            end
            LANE_HI: begin
                sel[1]         = 1'b1;
                entrada_pronta = pode_aceitar[1];
            end
            LANE_LO: begin
                sel[2]         = 1'b1;
                entrada_pronta = pode_aceitar[2];
            end
            LANE_MEM: begin
                sel[3]         = 1'b1;
                entrada_pronta = pode_aceitar[3];
            end
            default: begin
                sel[0]         = 1'b1;
                entrada_pronta = pode_aceitar[0];
            end
        endcase
    end

    assign aceita  = entrada_valida && entrada_pronta;
    assign escrita = aceita ? sel : '0;

    for (genvar i = 0; i < NUM_SAIDAS; i++) begin : g_lane
        registro_saida_hs #(
            .LARGURA(LARGURA)
        ) u_reg (
            .clock       (clock),
            .reset       (reset),
            .escrita     (escrita[i]),
            .dado        (entrada),
            .pronta      (saida_pronta[i]),
            .saida       (dados[i]),
            .valida      (saida_valida[i]),
            .pode_aceitar(pode_aceitar[i])
        );
    end

    assign saida1  = dados[0];
    assign saida2  = dados[1];
    assign saida3  = dados[2];
    assign saida4  = dados[3];
    // Derived only from registered valids, so no input-to-output path.
    assign ocupado = |saida_valida;

endmodule

// File: tb/tb_demux_32bits_4saidas_reg.sv
// Directed self-checking bench for the registered 1-to-4 distributor.
module tb_demux_32bits_4saidas_reg;

    logic        clock;
    logic        reset;
    logic [31:0] entrada;
    logic [1:0]  key;
    logic        entrada_valida;
    logic        entrada_pronta;
    logic [31:0] saida1, saida2, saida3, saida4;
    logic [3:0]  saida_valida;
    logic [3:0]  saida_pronta;
    logic        ocupado;

    int checks = 0;
    int errors = 0;

    logic        prev_blocked = 1'b0;
    logic [31:0] prev_entrada = '0;
    logic [1:0]  prev_key     = '0;

    demux_32bits_4saidas_reg #(
        .LARGURA   (32),
        .NUM_SAIDAS(4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .entrada       (entrada),
        .key           (key),
        .entrada_valida(entrada_valida),
        .entrada_pronta(entrada_pronta),
        .saida1        (saida1),
        .saida2        (saida2),
        .saida3        (saida3),
        .saida4        (saida4),
        .saida_valida  (saida_valida),
        .saida_pronta  (saida_pronta),
        .ocupado       (ocupado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Producer rule: an offer refused at an edge must be repeated unchanged at the next.
    always @(posedge clock) begin
        if (!reset && prev_blocked) begin
            checks++;
            if (!entrada_valida || entrada !== prev_entrada || key !== prev_key) begin
                errors++;
                $display("FAIL producer_hold: got valid=%b data=%h key=%0d required valid=1 data=%h key=%0d",
                         entrada_valida, entrada, key, prev_entrada, prev_key);
            end
        end
        prev_blocked <= !reset && entrada_valida && !entrada_pronta;
        prev_entrada <= entrada;
        prev_key     <= key;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk32(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", nome, got, exp);
        end
    endtask

    task automatic test_reset();
        tick();
        chk32("reset_valida", {28'd0, saida_valida}, 32'h0);
        chk32("reset_ocupado", {31'd0, ocupado}, 32'h0);
        chk32("reset_saida1", saida1, 32'h0);
        chk32("reset_saida2", saida2, 32'h0);
        chk32("reset_saida3", saida3, 32'h0);
        chk32("reset_saida4", saida4, 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            key = k[1:0];
            #1;
            chk32($sformatf("idle_pronta_key%0d", k), {31'd0, entrada_pronta}, 32'h1);
        end
    endtask

    task automatic test_routing();
        saida_pronta   = 4'b0000;
        key            = 2'd2;
        entrada        = 32'hDEADBEEF;
        entrada_valida = 1'b1;
        tick();
        entrada_valida = 1'b0;
        chk32("route_saida3", saida3, 32'hDEADBEEF);
        chk32("route_valida", {28'd0, saida_valida}, 32'h4);
        chk32("route_ocupado", {31'd0, ocupado}, 32'h1);
        chk32("route_saida1", saida1, 32'h0);
        chk32("route_saida2", saida2, 32'h0);
        chk32("route_saida4", saida4, 32'h0);
    endtask

    task automatic test_backpressure();
        key            = 2'd2;
        entrada        = 32'h12345678;
        entrada_valida = 1'b1;
        #1;
        chk32("bp_pronta_full", {31'd0, entrada_pronta}, 32'h0);
        key     = 2'd0;
        entrada = 32'h000000AA;
        #1;
        chk32("bp_pronta_other", {31'd0, entrada_pronta}, 32'h1);
        tick();
        entrada_valida = 1'b0;
        chk32("bp_saida3_kept", saida3, 32'hDEADBEEF);
        chk32("bp_saida1", saida1, 32'h000000AA);
        chk32("bp_valida", {28'd0, saida_valida}, 32'h5);
    endtask

    task automatic test_hold_and_refill();
        key            = 2'd2;
        entrada        = 32'h12345678;
        entrada_valida = 1'b1;
        tick();
        chk32("hold_saida3", saida3, 32'hDEADBEEF);
        chk32("hold_valida", {28'd0, saida_valida}, 32'h5);
        saida_pronta = 4'b0100;
        #1;
        chk32("hold_pronta_drain", {31'd0, entrada_pronta}, 32'h1);
        tick();
        entrada_valida = 1'b0;
        saida_pronta   = 4'b0000;
        chk32("refill_saida3", saida3, 32'h12345678);
        chk32("refill_valida", {28'd0, saida_valida}, 32'h5);
    endtask

    task automatic test_back_to_back();
        saida_pronta   = 4'b0001;
        key            = 2'd0;
        entrada        = 32'h11;
        entrada_valida = 1'b1;
        tick();
        chk32("b2b_saida1_a", saida1, 32'h11);
        chk32("b2b_valida_a", {31'd0, saida_valida[0]}, 32'h1);
        entrada = 32'h22;
        tick();
        chk32("b2b_saida1_b", saida1, 32'h22);
        chk32("b2b_valida_b", {31'd0, saida_valida[0]}, 32'h1);
        entrada_valida = 1'b0;
        tick();
        chk32("b2b_drained", {28'd0, saida_valida}, 32'h4);
        chk32("b2b_saida1_held", saida1, 32'h22);
        saida_pronta = 4'b0000;
    endtask

    task automatic test_full_drain();
        saida_pronta = 4'b1111;
        tick();
        chk32("fd_empty", {28'd0, saida_valida}, 32'h0);
        tick();
        chk32("fd_ready_when_empty", {28'd0, saida_valida}, 32'h0);
        saida_pronta   = 4'b0000;
        entrada_valida = 1'b1;
        for (int k = 0; k < 4; k++) begin
            key     = k[1:0];
            entrada = 32'hA0 + k;
            tick();
        end
        entrada_valida = 1'b0;
        chk32("fd_all_full", {28'd0, saida_valida}, 32'hF);
        chk32("fd_ocupado_full", {31'd0, ocupado}, 32'h1);
        saida_pronta = 4'b1111;
        tick();
        saida_pronta = 4'b0000;
        chk32("fd_valida", {28'd0, saida_valida}, 32'h0);
        chk32("fd_ocupado", {31'd0, ocupado}, 32'h0);
        chk32("fd_saida1", saida1, 32'hA0);
        chk32("fd_saida2", saida2, 32'hA1);
        chk32("fd_saida3", saida3, 32'hA2);
        chk32("fd_saida4", saida4, 32'hA3);
    endtask

    task automatic test_reset_mid();
        entrada_valida = 1'b1;
        key            = 2'd1;
        entrada        = 32'hB2;
        tick();
        key     = 2'd3;
        entrada = 32'hB4;
        tick();
        entrada_valida = 1'b0;
        chk32("rm_loaded", {28'd0, saida_valida}, 32'hA);
        reset = 1'b1;
        #1;
        chk32("rm_async_valida", {28'd0, saida_valida}, 32'h0);
        chk32("rm_async_ocupado", {31'd0, ocupado}, 32'h0);
        chk32("rm_async_saida2", saida2, 32'h0);
        key            = 2'd0;
        entrada        = 32'h77;
        entrada_valida = 1'b1;
        tick();
        chk32("rm_no_accept", {28'd0, saida_valida}, 32'h0);
        chk32("rm_no_accept_data", saida1, 32'h0);
        reset   = 1'b0;
        key     = 2'd3;
        entrada = 32'h55;
        tick();
        entrada_valida = 1'b0;
        chk32("rm_first_saida4", saida4, 32'h55);
        chk32("rm_first_valida", {28'd0, saida_valida}, 32'h8);
    endtask

    initial begin
        reset          = 1'b1;
        entrada        = '0;
        key            = '0;
        entrada_valida = 1'b0;
        saida_pronta   = '0;
        test_reset();
        test_routing();
        test_backpressure();
        test_hold_and_refill();
        test_back_to_back();
        test_full_drain();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
